// File: rtl/seq_restoring_divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state encodings.
package seq_restoring_divider_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_restoring_divider_trial_sub.sv
// Trial subtractor for the restoring divider: diff = a + ~b + 1.
// c_out is the carry out of that sum, so c_out = 1 exactly when a >= b (unsigned).
// This is the only arithmetic element in the divider.
module div_trial_sub #(
  parameter int W = 5
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         c_out
);

  logic [W:0] sum;

  assign sum          = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
  assign {c_out, diff} = sum;

endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider.
// One trial subtraction per cycle in RUN; N steps produce quotient and remainder.
// A zero divisor skips RUN and reports all-ones quotient, remainder = dividend,
// with div_by_zero set. Results and the flag hold until the next result is produced.
module seq_restoring_divider
  import seq_restoring_divider_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = $clog2(N + 1);

  state_t state;
  state_t state_next;

  logic [N:0]    r_reg;
  logic [N-1:0]  q_reg;
  logic [N-1:0]  d_reg;
  logic [CW-1:0] cnt;

  logic          accept;
  logic          zero_div;
  logic          last_step;
  logic [N:0]    r_shift;
  logic [N:0]    trial_diff;
  logic          trial_carry;
  logic [N:0]    r_step;
  logic [N-1:0]  q_step;

  // start is only honoured when no division is in flight
  assign accept    = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign zero_div  = (divisor == '0);
  assign last_step = (cnt == CW'(1));

  // Shift the next dividend bit into the partial remainder, then try to subtract D
  assign r_shift = {r_reg[N-1:0], q_reg[N-1]};

  div_trial_sub #(
    .W(N + 1)
  ) u_trial (
    .a     (r_shift),
    .b     ({1'b0, d_reg}),
    .diff  (trial_diff),
    .c_out (trial_carry)
  );

  // Keep the difference when it did not borrow, otherwise restore the shifted value
  assign r_step = trial_carry ? trial_diff : r_shift;
  assign q_step = {q_reg[N-2:0], trial_carry};

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: zero divisor jumps straight to DONE, RUN lasts N steps
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = zero_div ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (last_step) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (start) begin
          state_next = zero_div ? ST_DONE : ST_RUN;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Status outputs decoded from the state register only
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      ST_RUN:  busy = 1'b1;
      ST_DONE: done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // Datapath: capture operands on accept, one restoring step per RUN cycle, latch results
  always_ff @(posedge clk) begin
    if (rst) begin
      r_reg       <= '0;
      q_reg       <= '0;
      d_reg       <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      r_reg <= '0;
      q_reg <= dividend;
      d_reg <= divisor;
      cnt   <= CW'(N);
      if (zero_div) begin
        quotient    <= '1;
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end
    end else if (state == ST_RUN) begin
      r_reg <= r_step;
      q_reg <= q_step;
      cnt   <= cnt - CW'(1);
      if (last_step) begin
        quotient    <= q_step;
        remainder   <= r_step[N-1:0];
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule
